// File: rtl/aes_job_arbiter.sv
// Round-robin arbiter sharing one AES-128 core among N_REQ job ports, with a tagged response channel.
// Define AES_ARB_TIMEOUT_EN to enable the WAIT-state watchdog (TIMEOUT_CYC cycles, rsp_err on abort).
module aes_job_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic [N_REQ*DATA_W-1:0]  req_text_i,
    input  logic [N_REQ*DATA_W-1:0]  req_key_i,
    output logic                     core_start_o,
    output logic [DATA_W-1:0]        core_text_o,
    output logic [DATA_W-1:0]        core_key_o,
    input  logic                     core_done_i,
    input  logic [DATA_W-1:0]        core_result_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [$clog2(N_REQ)-1:0] rsp_id_o,
    output logic [DATA_W-1:0]        rsp_data_o,
    output logic                     rsp_err_o,
    output logic                     busy_o
);

    localparam int unsigned IdW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_cfg_check
        $error("aes_job_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

    state_e              state_q;
    logic [IdW-1:0]      rr_ptr_q;
    logic                core_start_q;
    logic [DATA_W-1:0]   core_text_q;
    logic [DATA_W-1:0]   core_key_q;
    logic                rsp_valid_q;
    logic [IdW-1:0]      rsp_id_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                busy_q;

    logic                found;
    logic [IdW-1:0]      winner;
    logic [IdW-1:0]      idx;
    logic [DATA_W-1:0]   text_sel;
    logic [DATA_W-1:0]   key_sel;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int unsigned   CntW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

    logic [CntW-1:0] wait_cnt_q;
    logic            rsp_err_q;

    assign rsp_err_o = rsp_err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

    // Index arithmetic modulo N_REQ, so the pointer never leaves 0..N_REQ-1.
    function automatic logic [IdW-1:0] wrap_add(input logic [IdW-1:0] base,
                                                input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return IdW'(s);
    endfunction

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = wrap_add(rr_ptr_q, k);
            if (!found && req_valid_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        text_sel = '0;
        key_sel  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (winner == IdW'(k)) begin
                text_sel = req_text_i[k*DATA_W +: DATA_W];
                key_sel  = req_key_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Gated by reset so every output reads zero while reset is held.
    always_comb begin
        req_ready_o = '0;
        if (rst_ni && state_q == StIdle && found) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            core_start_q <= 1'b0;
            core_text_q  <= '0;
            core_key_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            busy_q       <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
            wait_cnt_q   <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            core_start_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (found) begin
                        core_text_q  <= text_sel;
                        core_key_q   <= key_sel;
                        rsp_id_q     <= winner;
                        rr_ptr_q     <= wrap_add(winner, 1);
                        core_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= StLaunch;
                    end
                end
                StLaunch: begin
`ifdef AES_ARB_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                    state_q <= StWait;
                end
                StWait: begin
                    // core_done has priority over a coincident timeout
                    if (core_done_i) begin
                        rsp_data_q  <= core_result_i;
                        rsp_valid_q <= 1'b1;
`ifdef AES_ARB_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state_q     <= StResp;
                    end
`ifdef AES_ARB_TIMEOUT_EN
                    else if (wait_cnt_q == CntLast) begin
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
`endif
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign core_start_o = core_start_q;
    assign core_text_o  = core_text_q;
    assign core_key_o   = core_key_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_data_o   = rsp_data_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Self-checking bench for aes_job_arbiter: vector table, directed corner sequences and
// randomized traffic against a queue-level reference model of round-robin job sharing.
module tb_aes_job_arbiter;

    localparam int N = 4;
    localparam int W = 128;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_text;
    logic [N*W-1:0]   req_key;
    logic             core_start;
    logic [W-1:0]     core_text;
    logic [W-1:0]     core_key;
    logic             core_done;
    logic [W-1:0]     core_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [W-1:0]     rsp_data;
    logic             rsp_err;
    logic             busy;

    aes_job_arbiter #(
        .N_REQ      (N),
        .DATA_W     (W),
        .TIMEOUT_CYC(64)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_text_i   (req_text),
        .req_key_i    (req_key),
        .core_start_o (core_start),
        .core_text_o  (core_text),
        .core_key_o   (core_key),
        .core_done_i  (core_done),
        .core_result_i(core_result),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_data_o   (rsp_data),
        .rsp_err_o    (rsp_err),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bound_expired(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] core_fn(input logic [127:0] t, input logic [127:0] k);
        if (t == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return t ^ {k[63:0], k[127:64]} ^ 128'h5a;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Core model: done (with a result) core_lat+1 cycles after the start pulse, unless hung.
    int   core_lat = 4;
    bit   core_hang = 0;
    logic model_done;
    logic stray_done;
    int   cd;
    assign core_done = model_done | stray_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd          <= -1;
            model_done  <= 1'b0;
            core_result <= '0;
        end else begin
            model_done <= 1'b0;
            if (core_start) begin
                cd <= core_lat - 1;
            end else if (cd > 0) begin
                cd <= cd - 1;
            end else if (cd == 0) begin
                cd <= -1;
                if (!core_hang) begin
                    model_done  <= 1'b1;
                    core_result <= core_fn(core_text, core_key);
                end
            end
        end
    end

    // Event monitor, sampled mid-cycle.
    int start_cnt = 0;
    int rsp_cnt = 0;
    int grants[$];
    always @(negedge clk) begin
        if (rst_n) begin
            if (core_start) start_cnt++;
            if (rsp_valid && rsp_ready) rsp_cnt++;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) grants.push_back(i);
            end
        end
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        #1;
        while (req_ready == '0 && n < 100) begin
            tick();
            #1;
            n++;
        end
        if (n >= 100) bound_expired(name);
    endtask

    task automatic wait_rsp(input string name);
        int n;
        n = 0;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) bound_expired(name);
    endtask

    task automatic run_job(input int id, input logic [127:0] t, input logic [127:0] k);
        req_text[id*W +: W] = t;
        req_key[id*W +: W]  = k;
        req_valid = 4'b0001 << id;
        rsp_ready = 1'b1;
        wait_ready("job_grant_wait");
        check("job_ready", req_ready, 4'b0001 << id);
        tick();
        req_valid = '0;
        check("job_start", core_start, 1);
        wait_rsp("job_rsp_wait");
        check("job_rsp_id", rsp_id, id);
        check("job_rsp_data", rsp_data, core_fn(t, k));
        check("job_rsp_err", rsp_err, 0);
        tick();
    endtask

    typedef struct {
        int         prior;
        logic [3:0] valid;
        logic [3:0] ready;
    } vec_t;
    vec_t vecs[10];

    int            mrr, ew, best, d, g_prev, exp_id, n_grant_m, n_rsp_m, k0, s0, r0;
    bit            busy_m, launch_chk;
    logic [127:0]  exp_t, exp_k, exp_data;
    logic [3:0]    exp_ready;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_text = '0;
        req_key = '0;
        rsp_ready = 1'b1;
        stray_done = 1'b0;

        // Reset state, and round-robin with all requesters valid from reset
        for (int i = 0; i < N; i++) begin
            req_text[i*W +: W] = rand128();
            req_key[i*W +: W]  = rand128();
        end
        req_valid = 4'b1111;
        core_lat = 3;
        tick();
        tick();
        check("reset_ready", req_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_start", core_start, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_core_text", core_text, 0);
        check("reset_rsp_data", rsp_data, 0);
        grants.delete();
        rst_n = 1'b1;
        k0 = 0;
        while (grants.size() < 5 && k0 < 500) begin
            tick();
            k0++;
        end
        req_valid = '0;
        if (grants.size() < 5) bound_expired("rr_grants");
        else begin
            for (int i = 0; i < 5; i++) check($sformatf("rr_order_%0d", i), grants[i], i % N);
        end
        k0 = 0;
        while (busy && k0 < 100) begin
            tick();
            k0++;
        end
        check("rr_drain_busy", busy, 0);

        // Vector table: arbitration from a known pointer (set by a prior job)
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        vecs[0] = '{-1, 4'b0000, 4'b0000};
        vecs[1] = '{-1, 4'b1111, 4'b0001};
        vecs[2] = '{-1, 4'b1010, 4'b0010};
        vecs[3] = '{-1, 4'b1000, 4'b1000};
        vecs[4] = '{ 1, 4'b1111, 4'b0100};
        vecs[5] = '{ 1, 4'b0011, 4'b0001};
        vecs[6] = '{ 3, 4'b0110, 4'b0010};
        vecs[7] = '{ 2, 4'b1001, 4'b1000};
        vecs[8] = '{ 2, 4'b0111, 4'b0001};
        vecs[9] = '{ 0, 4'b1101, 4'b0100};
        core_lat = 2;
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].prior >= 0) run_job(vecs[v].prior, rand128(), rand128());
            req_valid = vecs[v].valid;
            #1;
            check($sformatf("vec_%0d_ready", v), req_ready, vecs[v].ready);
            req_valid = '0;
            tick();
        end

        // Single job, FIPS-197 vector, 31-cycle core
        core_lat = 31;
        s0 = start_cnt;
        grants.delete();
        run_job(2, FIPS_PT, FIPS_KEY);
        check("single_start_cycles", start_cnt - s0, 1);
        check("single_grants", grants.size(), 1);
        if (grants.size() == 1) check("single_grant_id", grants[0], 2);

        // Back-pressure: response held for 10 cycles while others wait
        core_lat = 4;
        exp_t = rand128();
        exp_k = rand128();
        req_text[1*W +: W] = exp_t;
        req_key[1*W +: W]  = exp_k;
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        wait_ready("bp_grant_wait");
        tick();
        req_valid = 4'b1101;
        wait_rsp("bp_rsp_wait");
        for (int c = 0; c <= 10; c++) begin
            #1;
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_id", rsp_id, 1);
            check("bp_rsp_data", rsp_data, core_fn(exp_t, exp_k));
            check("bp_req_ready", req_ready, 0);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        check("bp_idle_busy", busy, 0);
        check("bp_idle_rsp_valid", rsp_valid, 0);

        // Stray done in IDLE and in LAUNCH
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        tick();
        check("stray_idle_rsp", rsp_valid, 0);
        check("stray_idle_busy", busy, 0);
        r0 = rsp_cnt;
        core_lat = 8;
        exp_t = rand128();
        exp_k = rand128();
        req_text[0 +: W] = exp_t;
        req_key[0 +: W]  = exp_k;
        req_valid = 4'b0001;
        wait_ready("stray_grant_wait");
        tick();
        req_valid = '0;
        check("stray_launch_start", core_start, 1);
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        check("stray_launch_rsp", rsp_valid, 0);
        check("stray_launch_busy", busy, 1);
        wait_rsp("stray_rsp_wait");
        check("stray_rsp_data", rsp_data, core_fn(exp_t, exp_k));
        for (int c = 0; c < 20; c++) tick();
        check("stray_rsp_count", rsp_cnt - r0, 1);

        // Reset five cycles into the job
        core_lat = 20;
        req_text[2*W +: W] = rand128();
        req_valid = 4'b0100;
        wait_ready("rst_grant_wait");
        tick();
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) tick();
        rst_n = 1'b0;
        #1;
        check("rst_start", core_start, 0);
        check("rst_core_text", core_text, 0);
        check("rst_core_key", core_key, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_rr_ptr_zero", req_ready, 4'b0001);
        req_valid = '0;
        r0 = rsp_cnt;
        for (int c = 0; c < 40; c++) tick();
        check("rst_no_rsp", rsp_cnt - r0, 0);
        check("rst_idle_busy", busy, 0);

        // Randomized traffic against the reference model
        mrr = 0;
        busy_m = 0;
        launch_chk = 0;
        g_prev = -1;
        n_grant_m = 0;
        n_rsp_m = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c >= 1500 && !busy_m) break;
            tick();
            if (launch_chk) begin
                check("rand_start", core_start, 1);
                check("rand_core_text", core_text, exp_t);
                check("rand_core_key", core_key, exp_k);
                launch_chk = 0;
            end
            if (g_prev >= 0) begin
                req_valid[g_prev] = 1'b0;
                g_prev = -1;
            end
            for (int i = 0; i < N; i++) begin
                if (c < 1500 && !req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_text[i*W +: W] = rand128();
                    req_key[i*W +: W]  = rand128();
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            core_lat = $urandom_range(1, 6);
            #1;
            if (busy_m) begin
                check("rand_ready_busy", req_ready, 0);
                if (rsp_valid && rsp_ready) begin
                    check("rand_rsp_id", rsp_id, exp_id);
                    check("rand_rsp_data", rsp_data, exp_data);
                    check("rand_rsp_err", rsp_err, 0);
                    busy_m = 0;
                    n_rsp_m++;
                end
            end else begin
                check("rand_idle_rsp", rsp_valid, 0);
                best = N;
                ew = -1;
                for (int i = 0; i < N; i++) begin
                    if (req_valid[i]) begin
                        d = (i - mrr + N) % N;
                        if (d < best) begin
                            best = d;
                            ew = i;
                        end
                    end
                end
                exp_ready = (ew >= 0) ? (4'b0001 << ew) : 4'b0000;
                check("rand_ready", req_ready, exp_ready);
                if (ew >= 0) begin
                    busy_m = 1;
                    exp_id = ew;
                    exp_t = req_text[ew*W +: W];
                    exp_k = req_key[ew*W +: W];
                    exp_data = core_fn(exp_t, exp_k);
                    launch_chk = 1;
                    g_prev = ew;
                    mrr = (ew + 1) % N;
                    n_grant_m++;
                end
            end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        check("rand_balance", n_rsp_m, n_grant_m);
        tick();
        check("rand_end_busy", busy, 0);

        // Core that never finishes
        core_hang = 1;
        req_valid = 4'b0001;
        wait_ready("hang_grant_wait");
        tick();
        req_valid = '0;
        tick();
`ifdef AES_ARB_TIMEOUT_EN
        k0 = 0;
        while (!rsp_valid && k0 < 200) begin
            tick();
            k0++;
        end
        check("timeout_cycles", k0, 64);
        check("timeout_err", rsp_err, 1);
        check("timeout_data", rsp_data, 0);
        check("timeout_id", rsp_id, 0);
        tick();
        check("timeout_idle", busy, 0);
`else
        for (int c = 0; c < 300; c++) tick();
        check("hang_busy", busy, 1);
        check("hang_rsp_valid", rsp_valid, 0);
        check("hang_err", rsp_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_job_arbiter.md
Name: aes_job_arbiter

Overview:
- Shares one AES-128 encryption core among N_REQ requesters.
- Each requester presents a plaintext/key job over a valid/ready handshake. The arbiter grants one job at a time in round-robin order, launches the core with a single-cycle start pulse and holds the operands stable until the core reports done.
- The result is returned on a shared response channel tagged with the requester ID.
- Sits between the host-side job ports and the core's encryption FSM/datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 128, plaintext/key/ciphertext width.
- TIMEOUT_CYC, 64, maximum core cycles before abort (used only with AES_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester job valid.
- req_ready  out  N_REQ  per-requester job accept, one-hot or zero.
- req_text  in  N_REQ*DATA_W  packed plaintexts; requester i occupies bits [i*DATA_W +: DATA_W].
- req_key  in  N_REQ*DATA_W  packed keys, same packing as req_text.
- core_start  out  1  one-cycle launch pulse to the core.
- core_text  out  DATA_W  plaintext to the core, registered.
- core_key  out  DATA_W  key to the core, registered.
- core_done  in  1  core result valid, single-cycle pulse.
- core_result  in  DATA_W  ciphertext from the core.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  $clog2(N_REQ)  index of the requester that owns the response.
- rsp_data  out  DATA_W  ciphertext.
- rsp_err  out  1  response aborted by timeout.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, rr_ptr=0, all outputs 0, operand/result registers cleared.
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching from rr_ptr upward with wrap modulo N_REQ.
  - req_ready[winner]=1 combinationally in the same cycle; all other req_ready bits are 0. req_ready is 0 in every other state.
  - On accept: latch req_text/req_key of the winner into core_text/core_key, latch the winner index into rsp_id, set rr_ptr=(winner+1) mod N_REQ, go to LAUNCH.
  - No valid requests: stay in IDLE; rr_ptr unchanged.
- LAUNCH: core_start=1 for exactly this cycle; go to WAIT.
- WAIT:
  - core_text/core_key held constant.
  - On core_done=1: capture core_result into rsp_data, rsp_err=0, go to RESP.
  - core_done arriving while in IDLE, LAUNCH or RESP is ignored.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err held stable until rsp_ready=1.
  - On rsp_valid&rsp_ready: rsp_valid=0 next cycle, go to IDLE.
- Latency: accept at cycle T, core_start at T+1, rsp_valid one cycle after core_done.
- Minimum gap between successive accepts = core latency + 3 cycles when rsp_ready is held high.
- A requester that deasserts req_valid before its grant loses nothing; no stored state is kept for it.
- Requests arriving while busy wait in place; the next grant still follows the rr_ptr search.
- Reset mid-job: abandon immediately, no response; the core is reset separately by the same reset_n.
- rr_ptr must never index beyond N_REQ-1.

Optional Feature:
- Macro: AES_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT_CYC without core_done: go to RESP with rsp_err=1 and rsp_data=0.
  - If core_done and the timeout occur in the same cycle, core_done wins (rsp_err=0).
- Undefined: no counter; WAIT lasts indefinitely; rsp_err is tied to 0.

Test Plan:
- Single job. Requester 2 presents key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff; core model returns 69c4e0d86a7b0430d8cdb78070b4c55a after 31 cycles.
  - Required: req_ready[2] pulses once; core_start is high for exactly one cycle; rsp_id=2; rsp_data=69c4...c55a; rsp_err=0.
- Round-robin. All 4 requesters hold req_valid continuously from reset.
  - Required: grant order 0,1,2,3,0; no requester receives a second grant before all others have been granted.
- Back-pressure. rsp_ready held low for 10 cycles after rsp_valid rises.
  - Required: rsp_valid, rsp_id and rsp_data stable for all 10 cycles; req_ready stays 0; IDLE is re-entered one cycle after rsp_ready=1.
- Stray done. core_done pulsed while in IDLE and again in LAUNCH.
  - Required: no response is produced; the real done in WAIT produces exactly one response.
- Reset mid-WAIT. Assert reset_n=0 five cycles after core_start.
  - Required: all outputs 0 immediately; after release, rr_ptr=0 and no response is produced for the abandoned job.
- Timeout, with AES_ARB_TIMEOUT_EN and TIMEOUT_CYC=64. Core model never asserts done.
  - Required: rsp_valid=1 with rsp_err=1 and rsp_data=0 exactly 64 cycles after entry to WAIT.
  - Required: with the macro undefined, the arbiter stays busy indefinitely.
